bus_reader: RTL

//   Receiving end of the shared 32-bit tri-state datapath bus driven by the bufif32 drivers.

---
 rtl/bus_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_reader.sv
// Receiving end of a shared tri-state bus: round-robin grants one driver, waits a settle window,
// captures the bus and acknowledges the winner. Optional parity check: define BUS_READER_PARITY_EN.
module bus_reader #(
    parameter int WIDTH         = 32,
    parameter int NSRC          = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDW           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  req,
    input  logic [WIDTH-1:0] bus_in,
`ifdef BUS_READER_PARITY_EN
    input  logic             bus_par,
    output logic             par_err,
`endif
    output logic [NSRC-1:0]  drv_en,
    output logic [NSRC-1:0]  ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [IDW-1:0]   src_id,
    output logic             busy
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

    // Handshake: req is a level held by the source until it sees its ack bit, a one-cycle pulse
    // issued together with data_valid in the cycle after capture; req is only sampled in IDLE.
    state_t          state, state_nx;
    logic [IDW-1:0]  rr_ptr, rr_nx;
    logic [IDW-1:0]  grant_id, grant_nx;
    logic [IDW-1:0]  winner;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [NSRC-1:0] drv_nx, ack_nx;
    logic [NSRC-1:0] win_onehot, grant_onehot;
    logic            capture;

    // The highest offset is tried first so the candidate nearest rr_ptr overwrites the rest.
    always_comb begin
        winner = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            for (int i = 0; i < NSRC; i++) begin
                if (i == ((int'(rr_ptr) + k) % NSRC) && req[i]) begin
                    winner = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            win_onehot[i]   = (winner == IDW'(i));
            grant_onehot[i] = (grant_id == IDW'(i));
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        drv_nx   = drv_en;
        ack_nx   = '0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                drv_nx = '0;
                if (|req) begin
                    grant_nx = winner;
                    drv_nx   = win_onehot;
                    cnt_nx   = CW'(SETTLE_CYCLES - 1);
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    capture  = 1'b1;
                    ack_nx   = grant_onehot;
                    drv_nx   = '0;
                    rr_nx    = (grant_id == IDW'(NSRC - 1)) ? '0 : grant_id + 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                drv_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                drv_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
            drv_en     <= '0;
            ack        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            src_id     <= '0;
            busy       <= 1'b0;
`ifdef BUS_READER_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            cnt        <= cnt_nx;
            grant_id   <= grant_nx;
            rr_ptr     <= rr_nx;
            drv_en     <= drv_nx;
            ack        <= ack_nx;
            data_valid <= capture;
            busy       <= (state_nx != IDLE);
            if (capture) begin
                data_out <= bus_in;
                src_id   <= grant_id;
`ifdef BUS_READER_PARITY_EN
                par_err  <= ^{bus_in, bus_par};
`endif
            end
        end
    end

endmodule
